// File: rtl/fetch_exc_stage_if.sv
// rtl/fetch_exc_stage_if.sv - fetch/decode exception stage bus bundle
//
// Groups the fetch-side inputs, the kill strobe and the registered D-stage,
// BadVAddr and fault-counter outputs of fetch_exc_stage.
//   master : drives pc_f/valid_f/bd_f/stall/flush/clr_bad, observes the rest
//   slave  : the stage itself
interface fetch_exc_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic [ADDR_W-1:0] pc_f;
  logic              valid_f;
  logic              bd_f;
  logic              stall;
  logic              flush;
  logic              clr_bad;
  logic              kill_f;
  logic [EXC_W-1:0]  exc_code_d;
  logic [ADDR_W-1:0] pc_d;
  logic              bd_d;
  logic              valid_d;
  logic [ADDR_W-1:0] badvaddr;
  logic              badvaddr_valid;
  logic [CNT_W-1:0]  fault_cnt;

  modport master (
    output pc_f, valid_f, bd_f, stall, flush, clr_bad,
    input  kill_f, exc_code_d, pc_d, bd_d, valid_d, badvaddr, badvaddr_valid, fault_cnt
  );

  modport slave (
    input  pc_f, valid_f, bd_f, stall, flush, clr_bad,
    output kill_f, exc_code_d, pc_d, bd_d, valid_d, badvaddr, badvaddr_valid, fault_cnt
  );
endinterface

// File: rtl/fetch_exc_stage.sv
// rtl/fetch_exc_stage.sv - fetch address-error check with F/D register, BadVAddr capture and fault counter
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fetch_exc_stage_if.slave
//           in  pc_f, valid_f, bd_f, stall, flush, clr_bad
//           out kill_f (combinational), exc_code_d, pc_d, bd_d, valid_d,
//               badvaddr, badvaddr_valid, fault_cnt
module fetch_exc_stage #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  TEXT_BASE  = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0]  TEXT_LIMIT = ADDR_W'(32'h0000_4ffc),
  parameter int unsigned        ALIGN_BITS = 2,
  parameter int unsigned        EXC_W      = 5,
  parameter logic [EXC_W-1:0]   CODE_ADEL  = EXC_W'(4),
  parameter int unsigned        CNT_W      = 8
) (
  input  logic           clk,
  input  logic           reset,
  fetch_exc_stage_if.slave bus
);

  logic              misalign;
  logic              aderr;
  logic              fault_f;
  logic              load;

  logic [EXC_W-1:0]  exc_code_q, exc_code_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              bd_q, bd_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;
  logic              badvaddr_valid_q, badvaddr_valid_d;
  logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

  // A zero-width alignment field cannot be sliced, so the check is
  // removed entirely when ALIGN_BITS is 0.
  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign misalign = |bus.pc_f[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  assign aderr   = (bus.pc_f < TEXT_BASE) | (bus.pc_f > TEXT_LIMIT) | misalign;
  assign fault_f = aderr & bus.valid_f;
  assign load    = ~bus.flush & ~bus.stall;

  always_comb begin
    exc_code_d       = exc_code_q;
    pc_d             = pc_q;
    bd_d             = bd_q;
    valid_d          = valid_q;
    badvaddr_d       = badvaddr_q;
    badvaddr_valid_d = badvaddr_valid_q;
    fault_cnt_d      = fault_cnt_q;

    // flush outranks stall; stall simply leaves the defaults (hold).
    if (bus.flush) begin
      exc_code_d = '0;
      pc_d       = '0;
      bd_d       = 1'b0;
      valid_d    = 1'b0;
    end else if (load) begin
      exc_code_d = fault_f ? CODE_ADEL : '0;
      pc_d       = bus.pc_f;
      bd_d       = bus.bd_f & bus.valid_f;
      valid_d    = bus.valid_f;
    end

    // First fault since the last clear wins; a clear in the same cycle as a
    // capturing load re-arms and captures in one step.
    if (load && fault_f && (!badvaddr_valid_q || bus.clr_bad)) begin
      badvaddr_d       = bus.pc_f;
      badvaddr_valid_d = 1'b1;
    end else if (bus.clr_bad && !(load && fault_f)) begin
      badvaddr_valid_d = 1'b0;
    end

    if (load && fault_f && (fault_cnt_q != {CNT_W{1'b1}})) begin
      fault_cnt_d = fault_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_code_q       <= '0;
      pc_q             <= '0;
      bd_q             <= 1'b0;
      valid_q          <= 1'b0;
      badvaddr_q       <= '0;
      badvaddr_valid_q <= 1'b0;
      fault_cnt_q      <= '0;
    end else begin
      exc_code_q       <= exc_code_d;
      pc_q             <= pc_d;
      bd_q             <= bd_d;
      valid_q          <= valid_d;
      badvaddr_q       <= badvaddr_d;
      badvaddr_valid_q <= badvaddr_valid_d;
      fault_cnt_q      <= fault_cnt_d;
    end
  end

  assign bus.kill_f         = fault_f;
  assign bus.exc_code_d     = exc_code_q;
  assign bus.pc_d           = pc_q;
  assign bus.bd_d           = bd_q;
  assign bus.valid_d        = valid_q;
  assign bus.badvaddr       = badvaddr_q;
  assign bus.badvaddr_valid = badvaddr_valid_q;
  assign bus.fault_cnt      = fault_cnt_q;

endmodule

// File: tb/tb_fetch_exc_stage.sv
// tb/tb_fetch_exc_stage.sv - scoreboard bench for fetch_exc_stage (default build and ALIGN_BITS=0/CNT_W=2 build)
module tb_fetch_exc_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_exc_stage_if #(.ADDR_W(32), .EXC_W(5), .CNT_W(8)) if_a ();
  fetch_exc_stage_if #(.ADDR_W(32), .EXC_W(5), .CNT_W(2)) if_b ();

  fetch_exc_stage #(.ADDR_W(32), .ALIGN_BITS(2), .EXC_W(5), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  fetch_exc_stage #(.ADDR_W(32), .ALIGN_BITS(0), .EXC_W(5), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  assign if_b.pc_f    = if_a.pc_f;
  assign if_b.valid_f = if_a.valid_f;
  assign if_b.bd_f    = if_a.bd_f;
  assign if_b.stall   = if_a.stall;
  assign if_b.flush   = if_a.flush;
  assign if_b.clr_bad = if_a.clr_bad;

  typedef struct {
    bit [31:0] pc;
    bit        vld;
    bit        bd;
    bit [4:0]  exc;
    bit [31:0] bad;
    bit        bv;
    int        cnt;
  } st_t;

  typedef struct {
    bit  rst;
    bit  kill_a;
    bit  kill_b;
    st_t a;
    st_t b;
  } exp_t;

  exp_t exp_q[$];
  st_t  mdl_a, mdl_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: legal window 0x3000..0x4ffc inclusive, word aligned unless
  // the alignment rule is disabled.
  function automatic bit addr_bad(bit [31:0] pc, int align);
    longint unsigned p = pc;
    if (p < 64'h3000 || p > 64'h4ffc) return 1'b1;
    if (align > 0 && (p % (64'd1 << align)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic st_t step(st_t s, bit rs, bit fl, bit stl, bit clr,
                               bit [31:0] pc, bit vf, bit bd, int align, int cmax);
    st_t n = s;
    bit  fa = vf && addr_bad(pc, align);
    bit  ld = !fl && !stl;
    if (rs) begin
      n = '{default: 0};
      return n;
    end
    if (fl) begin
      n.pc = 0; n.vld = 0; n.bd = 0; n.exc = 0;
    end else if (ld) begin
      n.pc = pc; n.vld = vf; n.bd = bd && vf; n.exc = fa ? 5'd4 : 5'd0;
    end
    if (ld && fa) begin
      if (!s.bv || clr) begin
        n.bad = pc; n.bv = 1;
      end
      if (s.cnt < cmax) n.cnt = s.cnt + 1;
    end else if (clr) begin
      n.bv = 0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit [31:0] pc, input bit vf, input bit bd,
                       input bit stl, input bit fl, input bit clr, input bit rs);
    exp_t e;
    @(negedge clk);
    reset        = rs;
    if_a.pc_f    = pc;
    if_a.valid_f = vf;
    if_a.bd_f    = bd;
    if_a.stall   = stl;
    if_a.flush   = fl;
    if_a.clr_bad = clr;
    e.rst    = rs;
    e.kill_a = vf && addr_bad(pc, 2);
    e.kill_b = vf && addr_bad(pc, 0);
    mdl_a    = step(mdl_a, rs, fl, stl, clr, pc, vf, bd, 2, 255);
    mdl_b    = step(mdl_b, rs, fl, stl, clr, pc, vf, bd, 0, 3);
    e.a      = mdl_a;
    e.b      = mdl_b;
    exp_q.push_back(e);
  endtask

  task automatic load_pc(input bit [31:0] pc);
    drive(pc, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: kill_f and asynchronous reset are checked between edges while
  // the inputs are stable; the registered state just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("kill_f_a", 32'(if_a.kill_f), 32'(e.kill_a));
        chk("kill_f_b", 32'(if_b.kill_f), 32'(e.kill_b));
        if (e.rst) begin
          chk("async_rst_valid_d", 32'(if_a.valid_d), 32'd0);
          chk("async_rst_pc_d", if_a.pc_d, 32'd0);
          chk("async_rst_exc", 32'(if_a.exc_code_d), 32'd0);
          chk("async_rst_cnt", 32'(if_a.fault_cnt), 32'd0);
          chk("async_rst_bv", 32'(if_a.badvaddr_valid), 32'd0);
          chk("async_rst_bad", if_a.badvaddr, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("pc_d", if_a.pc_d, e.a.pc);
        chk("valid_d", 32'(if_a.valid_d), 32'(e.a.vld));
        chk("bd_d", 32'(if_a.bd_d), 32'(e.a.bd));
        chk("exc_code_d_a", 32'(if_a.exc_code_d), 32'(e.a.exc));
        chk("badvaddr_a", if_a.badvaddr, e.a.bad);
        chk("badvaddr_valid_a", 32'(if_a.badvaddr_valid), 32'(e.a.bv));
        chk("fault_cnt_a", 32'(if_a.fault_cnt), 32'(e.a.cnt));
        chk("exc_code_d_b", 32'(if_b.exc_code_d), 32'(e.b.exc));
        chk("badvaddr_b", if_b.badvaddr, e.b.bad);
        chk("badvaddr_valid_b", 32'(if_b.badvaddr_valid), 32'(e.b.bv));
        chk("fault_cnt_b", 32'(if_b.fault_cnt), 32'(e.b.cnt));
        chk("valid_d_b", 32'(if_b.valid_d), 32'(e.b.vld));
      end
    end
  end

  initial begin
    bit [31:0] pc;
    mdl_a = '{default: 0};
    mdl_b = '{default: 0};
    if_a.pc_f = 0; if_a.valid_f = 0; if_a.bd_f = 0;
    if_a.stall = 0; if_a.flush = 0; if_a.clr_bad = 0;

    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // Build up valid_d = 1 and fault_cnt = 3, then reset mid-run.
    load_pc(32'h2ffc); load_pc(32'h5000); load_pc(32'hffff_fffc);
    load_pc(32'h3000);
    drive(32'h3000, 1, 0, 0, 0, 0, 1);
    load_pc(32'h3000);

    // Range edges.
    load_pc(32'h2ffc); load_pc(32'h3000); load_pc(32'h4ffc);
    load_pc(32'h5000); load_pc(32'hffff_fffc);

    // Alignment, with and without a real fetch.
    load_pc(32'h3002);
    drive(32'h3002, 0, 0, 0, 0, 0, 0);

    // Faulting PC held by stall, counted once when stall drops.
    repeat (3) drive(32'h5000, 1, 0, 1, 0, 0, 0);
    load_pc(32'h5000);
    drive(32'h5000, 1, 0, 1, 1, 0, 0);

    // Sticky clear: recapture in the same cycle, then clear alone.
    drive(32'h6000, 1, 0, 0, 0, 1, 0);
    drive(32'h3000, 1, 0, 0, 0, 1, 0);
    load_pc(32'h3008);

    // Saturation from a fresh count.
    drive(0, 0, 0, 0, 0, 0, 1);
    repeat (5) load_pc(32'h5000);

    // Delay slot.
    drive(32'h3004, 1, 1, 0, 0, 0, 0);
    drive(32'h3004, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 5: pc = 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
        1: begin
          case ($urandom_range(0, 3))
            0: pc = 32'h2ffc;
            1: pc = 32'h3000;
            2: pc = 32'h4ffc;
            default: pc = 32'h5000;
          endcase
        end
        2: pc = 32'h3000 + $urandom_range(0, 32'h1fff);
        3: pc = $urandom;
        default: pc = 32'hffff_fffc;
      endcase
      drive(pc, ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_exc_stage.md
Name: fetch_exc_stage

Overview:
Parametrised fetch-stage exception unit with an integrated F/D pipeline register for the MIPS pipeline.
- Checks each fetched PC against a configurable instruction-memory window and alignment rule, and raises AdEL.
- Carries the exception code, PC and delay-slot flag into D with stall/flush control.
- Keeps a sticky BadVAddr capture and a saturating fault counter for CP0 and debug.

Parameters:
ADDR_W, 32, PC width
TEXT_BASE, 32'h0000_3000, lowest legal fetch address (inclusive)
TEXT_LIMIT, 32'h0000_4ffc, highest legal fetch address (inclusive)
ALIGN_BITS, 2, number of low PC bits that must be zero; 0 disables the alignment check
EXC_W, 5, exception code width (maps to ExcCode[6:2])
CODE_ADEL, 4, code emitted for a fetch address error
CNT_W, 8, fault counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
pc_f  in  ADDR_W  PC being fetched this cycle
valid_f  in  1  pc_f is a real fetch (0 = bubble)
bd_f  in  1  fetched instruction sits in a branch delay slot
stall  in  1  hold F/D register
flush  in  1  squash F/D register (exception entry / eret)
clr_bad  in  1  clear sticky BadVAddr capture
kill_f  out  1  combinational: the instruction fetched at pc_f must be replaced by nop
exc_code_d  out  EXC_W  registered exception code in D (0 = none)
pc_d  out  ADDR_W  registered PC in D
bd_d  out  1  registered delay-slot flag
valid_d  out  1  registered valid
badvaddr  out  ADDR_W  first faulting PC since last clear
badvaddr_valid  out  1  badvaddr holds a capture
fault_cnt  out  CNT_W  saturating count of AdEL events loaded into D

Behaviour:
- Combinational check (unsigned compares):
  - aderr = pc_f < TEXT_BASE, or pc_f > TEXT_LIMIT, or (ALIGN_BITS > 0 and pc_f[ALIGN_BITS-1:0] != 0).
  - fault_f = aderr & valid_f.
  - kill_f = fault_f, with zero latency; it is independent of stall and flush.
- Load condition: load = ~reset & ~flush & ~stall. Register priority: reset > flush > stall > load.
- Reset (async, immediate):
  - exc_code_d = 0, pc_d = 0, bd_d = 0, valid_d = 0.
  - badvaddr = 0, badvaddr_valid = 0, fault_cnt = 0.
- flush = 1: next edge sets valid_d = 0, exc_code_d = 0, bd_d = 0, pc_d = 0. flush also overrides stall in the same cycle.
- stall = 1 with flush = 0: all F/D outputs hold.
- load:
  - valid_d <= valid_f, pc_d <= pc_f, bd_d <= bd_f & valid_f.
  - exc_code_d <= fault_f ? CODE_ADEL : 0.
  - Latency from pc_f to the D outputs is 1 cycle.
- Sticky capture, updated only on a load with fault_f = 1:
  - If badvaddr_valid = 0, or clr_bad = 1 in the same cycle: badvaddr <= pc_f, badvaddr_valid <= 1.
  - Otherwise badvaddr holds, so the first fault wins.
- clr_bad = 1 without a capturing load: badvaddr_valid <= 0 next edge. badvaddr keeps its stale value.
- fault_cnt increments by 1 on each load with fault_f = 1. It saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- Stalled and flushed cycles never update capture or count, even when fault_f = 1.
- Boundaries:
  - pc_f == TEXT_BASE and pc_f == TEXT_LIMIT are legal.
  - TEXT_LIMIT+4 is illegal.
  - 32'hFFFF_FFFC is illegal; the compares do not wrap.
- A faulting PC that is held by stall is loaded and counted exactly once, on the cycle stall drops.

Test Plan:
- Reset asserted mid-run with valid_d = 1 and fault_cnt = 3 -> all outputs 0 immediately, before the next clk edge. After release, pc_f = 32'h3000 with valid_f = 1 -> next edge: pc_d = 32'h3000, exc_code_d = 0, valid_d = 1.
- Range edges, one per cycle, valid_f = 1: pc_f = 32'h2ffc, 32'h3000, 32'h4ffc, 32'h5000, 32'hffff_fffc -> kill_f = 1,0,0,1,1. exc_code_d one cycle later = 4,0,0,4,4. fault_cnt ends at 3 and badvaddr = 32'h2ffc (first fault wins).
- Alignment: pc_f = 32'h3002 -> kill_f = 1 and exc_code_d = 4. With valid_f = 0 and pc_f = 32'h3002 -> kill_f = 0, exc_code_d = 0, valid_d = 0, count unchanged. Variant build with ALIGN_BITS = 0: pc_f = 32'h3002 -> exc_code_d = 0.
- Stall/flush:
  - pc_f = 32'h5000, stall = 1 for 3 cycles -> D outputs hold, fault_cnt unchanged. stall drops -> exc_code_d = 4, fault_cnt +1 exactly once.
  - stall = 1 and flush = 1 together -> valid_d = 0, exc_code_d = 0.
- Sticky clear:
  - badvaddr = 32'h2ffc; clr_bad = 1 on a cycle loading pc_f = 32'h6000 -> badvaddr = 32'h6000, badvaddr_valid = 1.
  - clr_bad alone -> badvaddr_valid = 0.
- Saturation: build with CNT_W = 2 and feed 5 consecutive faulting loads -> fault_cnt = 1,2,3,3,3.
- Delay slot: bd_f = 1 with pc_f = 32'h3004 -> bd_d = 1. With valid_f = 0 -> bd_d = 0.
